nv_nvdla_dmaif_wr_arb: RTL and testbench
========================================

Name: nv_nvdla_dmaif_wr_arb

Overview:
- Two-requester arbiter that shares one DMA write-request port between two write DMA clients, e.g. SDP WDMA (requester 0) and PDP WDMA (requester 1).
- Grants whole transactions (one cmd packet plus its data packets) without interleaving.
- Tracks which requester owns each acked write and routes the write-complete response back to that requester.
- Sits between the client WDMA engines and the DMAIF write interface.

Parameters:
- ACK_DEPTH, 8, entries in the owner-tracking FIFO (power of 2, ≥2).
- PD_W, 66, request packet width; fixed by the DMA write packet format.

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rstn  in  1  async active-low reset
- req0_pd  in  PD_W  requester 0 packet
- req0_pvld  in  1  requester 0 valid
- req0_prdy  out  1  requester 0 ready
- req1_pd  in  PD_W  requester 1 packet
- req1_pvld  in  1  requester 1 valid
- req1_prdy  out  1  requester 1 ready
- dma_wr_req_pd  out  PD_W  granted packet
- dma_wr_req_pvld  out  1  granted valid
- dma_wr_req_prdy  in  1  downstream ready
- dma_wr_rsp_complete  in  1  one pulse per completed acked write
- rsp0_complete  out  1  completion pulse to requester 0
- rsp1_complete  out  1  completion pulse to requester 1
- arb_err  out  1  sticky protocol-error flag

Behaviour:
- Clocking and reset: single clock nvdla_core_clk; reset nvdla_core_rstn is asynchronous, active-low.
- Reset values: all outputs 0; state=ARB; last_grant=1, so requester 0 wins first; FIFO empty; beat counter 0; arb_err=0.
- Packet format:
  - pd[65] is the packet type: 0=cmd, 1=data.
  - cmd: addr [31:0], size [44:32] (data beats = size+1), require_ack [45].
  - data: payload [64:0].
- Handshake: a transfer occurs when pvld&prdy. The datapath is a zero-latency combinational mux. dma_wr_req_pvld must never depend on dma_wr_req_prdy.
- ARB state:
  - A requester is eligible iff pvld=1, pd[65]=0, and NOT (pd[45]=1 AND ack FIFO full).
  - If both are eligible, the requester != last_grant wins. If one is eligible, it wins.
  - The winner's packet is driven out, and winner prdy = dma_wr_req_prdy; the loser's prdy=0.
  - On accepted cmd: last_grant←winner; beat_cnt←size; owner←winner; go to XFER.
  - If require_ack=1, push winner ID into the ack FIFO in the same cycle.
- Data packet at a requester head while in ARB: that requester is ineligible and arb_err is set. The requester stays stalled; no packet is dropped.
- XFER state:
  - Only the owner is muxed through; the other requester's prdy=0.
  - Each accepted data beat: beat_cnt decrements. The accept with beat_cnt==0 returns to ARB on the next cycle.
  - A cmd packet (pd[65]=0) from the owner while in XFER sets arb_err and is still forwarded as a beat.
- Ack routing:
  - On dma_wr_rsp_complete, pop the FIFO head. rspN_complete pulses for exactly 1 cycle, registered (1-cycle latency).
  - Push and pop in the same cycle are both honoured (count unchanged), including when the FIFO is full, provided the pop frees the slot.
  - Complete with the FIFO empty: no pulse, arb_err set.
- Counters: FIFO count is $clog2(ACK_DEPTH)+1 bits. beat_cnt is 13 bits with no wrap (size max 8191 → 8192 beats).
- Reset mid-transaction: all state clears immediately; outstanding ownership is discarded.

Optional Feature:
- NVDLA_DMAIF_WR_ARB_PERF_EN defined:
  - Adds output ports arb_stall0 [31:0] and arb_stall1 [31:0].
  - Each counts cycles with reqN_pvld=1 and reqN_prdy=0, saturating at 0xFFFFFFFF.
  - The counters clear on reset.
- Undefined: the ports and counters are absent.

Decomposition:
- Shared package: constants PKT_TYPE_BIT=65, CMD_SIZE_LSB=32, CMD_SIZE_W=13, CMD_REQACK_BIT=45, PD_W=66.
- Shared package: state enum {ARB, XFER}.
- One sub-module: nv_nvdla_dmaif_wr_arb_ackfifo, a 1-bit-wide flop FIFO with push, pop, full, empty and count.

Test Plan:
- Both requesters present cmd size=3 together from reset → req0 granted, 4 data beats with req1_prdy=0 throughout; then req1 granted.
- Requester 0 sends a cmd with require_ack=1; complete pulse 20 cycles later → rsp0_complete high for exactly 1 cycle, on the cycle after the pulse; rsp1_complete stays 0.
- Interleaved acked cmds in order req1, req0, req1, then 3 completes → rsp pulses in order 1, 0, 1.
- Fill the FIFO with 8 acked cmds → a 9th acked cmd is blocked (prdy=0) while a non-acked cmd from the other requester is still granted. A complete arriving in the same cycle as the blocked cmd unblocks it.
- Data packet presented in ARB → arb_err=1 and nothing forwarded. Complete with the FIFO empty → no rsp pulse.
- dma_wr_req_prdy toggled randomly during XFER size=8191 → exactly 8192 data beats forwarded, then ARB.

Source files
------------

// File: rtl/nv_nvdla_dmaif_wr_arb_pkg.sv
// Shared constants and state encoding for the DMAIF write-request arbiter.
// Packet layout: pd[65] type (0=cmd, 1=data); cmd addr[31:0], size[44:32], require_ack[45].
package nv_nvdla_dmaif_wr_arb_pkg;

    localparam int unsigned PD_W           = 66;
    localparam int unsigned PKT_TYPE_BIT   = 65;
    localparam int unsigned CMD_SIZE_LSB   = 32;
    localparam int unsigned CMD_SIZE_W     = 13;
    localparam int unsigned CMD_REQACK_BIT = 45;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

endpackage

// File: rtl/nv_nvdla_dmaif_wr_arb_ackfifo.sv
// Flop FIFO of 1-bit requester IDs for writes awaiting their completion response.
// Push and pop in the same cycle are both honoured, including when full.
module nv_nvdla_dmaif_wr_arb_ackfifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     nvdla_core_clk,
    input  logic                     nvdla_core_rstn,
    input  logic                     push,
    input  logic                     push_data,
    input  logic                     pop,
    output logic                     pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/nv_nvdla_dmaif_wr_arb.sv
// Two-requester write-DMA arbiter: grants whole cmd+data transactions and routes
// write-complete pulses back to the owner. Define NVDLA_DMAIF_WR_ARB_PERF_EN for stall counters.
module nv_nvdla_dmaif_wr_arb
    import nv_nvdla_dmaif_wr_arb_pkg::*;
#(
    parameter int unsigned ACK_DEPTH = 8
) (
    input  logic            nvdla_core_clk,
    input  logic            nvdla_core_rstn,
    input  logic [PD_W-1:0] req0_pd,
    input  logic            req0_pvld,
    output logic            req0_prdy,
    input  logic [PD_W-1:0] req1_pd,
    input  logic            req1_pvld,
    output logic            req1_prdy,
    output logic [PD_W-1:0] dma_wr_req_pd,
    output logic            dma_wr_req_pvld,
    input  logic            dma_wr_req_prdy,
    input  logic            dma_wr_rsp_complete,
    output logic            rsp0_complete,
    output logic            rsp1_complete,
    output logic            arb_err
`ifdef NVDLA_DMAIF_WR_ARB_PERF_EN
    ,
    output logic [31:0]     arb_stall0,
    output logic [31:0]     arb_stall1
`endif
);

    localparam int unsigned CNT_W = $clog2(ACK_DEPTH) + 1;

    arb_state_e             state;
    arb_state_e             nxt_state;
    logic                   last_grant;
    logic                   nxt_last_grant;
    logic                   owner;
    logic                   nxt_owner;
    logic [CMD_SIZE_W-1:0]  beat_cnt;
    logic [CMD_SIZE_W-1:0]  nxt_beat_cnt;

    logic                   sel;
    logic                   sel_vld;
    logic [PD_W-1:0]        sel_pd;
    logic                   grant_en;
    logic                   accept;
    logic                   elig0;
    logic                   elig1;
    logic                   ack_blocked;
    logic                   ack_push;
    logic                   ack_pop;
    logic                   ack_head;
    logic                   ack_full;
    logic                   ack_empty;
    logic [CNT_W-1:0]       ack_cnt;
    logic                   err_set;

    nv_nvdla_dmaif_wr_arb_ackfifo #(
        .DEPTH (ACK_DEPTH)
    ) u_ackfifo (
        .nvdla_core_clk  (nvdla_core_clk),
        .nvdla_core_rstn (nvdla_core_rstn),
        .push            (ack_push),
        .push_data       (sel),
        .pop             (ack_pop),
        .pop_data        (ack_head),
        .full            (ack_full),
        .empty           (ack_empty),
        .count           (ack_cnt)
    );

    always_comb begin
        assert (ack_cnt <= CNT_W'(ACK_DEPTH));
    end

    // A completion in the same cycle frees a slot, so a full FIFO does not block then.
    assign ack_blocked = ack_full && !dma_wr_rsp_complete;
    assign ack_pop     = dma_wr_rsp_complete && !ack_empty;

    assign elig0 = req0_pvld && !req0_pd[PKT_TYPE_BIT] && !(req0_pd[CMD_REQACK_BIT] && ack_blocked);
    assign elig1 = req1_pvld && !req1_pd[PKT_TYPE_BIT] && !(req1_pd[CMD_REQACK_BIT] && ack_blocked);

    // Requester selection: owner during XFER, round-robin among eligible cmds in ARB.
    always_comb begin
        sel     = owner;
        sel_vld = 1'b0;
        if (state == XFER) begin
            sel_vld = owner ? req1_pvld : req0_pvld;
        end else if (elig0 || elig1) begin
            sel_vld = 1'b1;
            sel     = (elig0 && elig1) ? ~last_grant : elig1;
        end
    end

    assign sel_pd          = sel ? req1_pd : req0_pd;
    assign grant_en        = (state == XFER) || sel_vld;
    assign req0_prdy       = grant_en && !sel && dma_wr_req_prdy;
    assign req1_prdy       = grant_en &&  sel && dma_wr_req_prdy;
    assign dma_wr_req_pvld = sel_vld;
    assign dma_wr_req_pd   = sel_vld ? sel_pd : '0;
    assign accept          = sel_vld && dma_wr_req_prdy;

    always_comb begin
        nxt_state      = state;
        nxt_last_grant = last_grant;
        nxt_owner      = owner;
        nxt_beat_cnt   = beat_cnt;
        ack_push       = 1'b0;
        case (state)
            ARB: begin
                if (accept) begin
                    nxt_state      = XFER;
                    nxt_last_grant = sel;
                    nxt_owner      = sel;
                    nxt_beat_cnt   = sel_pd[CMD_SIZE_LSB +: CMD_SIZE_W];
                    ack_push       = sel_pd[CMD_REQACK_BIT];
                end
            end
            XFER: begin
                if (accept) begin
                    if (beat_cnt == '0) begin
                        nxt_state = ARB;
                    end else begin
                        nxt_beat_cnt = beat_cnt - CMD_SIZE_W'(1);
                    end
                end
            end
            default: nxt_state = ARB;
        endcase
    end

    // Protocol errors: data at a head in ARB, cmd mid-transaction, completion with nothing owed.
    assign err_set = ((state == ARB) &&
                      ((req0_pvld && req0_pd[PKT_TYPE_BIT]) || (req1_pvld && req1_pd[PKT_TYPE_BIT]))) ||
                     ((state == XFER) && accept && !sel_pd[PKT_TYPE_BIT]) ||
                     (dma_wr_rsp_complete && ack_empty);

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state         <= ARB;
            last_grant    <= 1'b1;
            owner         <= 1'b0;
            beat_cnt      <= '0;
            rsp0_complete <= 1'b0;
            rsp1_complete <= 1'b0;
            arb_err       <= 1'b0;
        end else begin
            state         <= nxt_state;
            last_grant    <= nxt_last_grant;
            owner         <= nxt_owner;
            beat_cnt      <= nxt_beat_cnt;
            rsp0_complete <= ack_pop && !ack_head;
            rsp1_complete <= ack_pop &&  ack_head;
            arb_err       <= arb_err || err_set;
        end
    end

`ifdef NVDLA_DMAIF_WR_ARB_PERF_EN
    // Saturating count of cycles each requester is held off.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            arb_stall0 <= '0;
            arb_stall1 <= '0;
        end else begin
            if (req0_pvld && !req0_prdy && (arb_stall0 != '1)) begin
                arb_stall0 <= arb_stall0 + 32'd1;
            end
            if (req1_pvld && !req1_prdy && (arb_stall1 != '1)) begin
                arb_stall1 <= arb_stall1 + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nv_nvdla_dmaif_wr_arb.sv
// Scoreboard bench for nv_nvdla_dmaif_wr_arb: expected packets and completion IDs are
// queued as stimulus is issued and compared as the DUT forwards them.
module tb_nv_nvdla_dmaif_wr_arb;

    typedef logic [65:0] pd_t;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rstn;
    pd_t         req0_pd;
    logic        req0_pvld;
    logic        req0_prdy;
    pd_t         req1_pd;
    logic        req1_pvld;
    logic        req1_prdy;
    pd_t         dma_wr_req_pd;
    logic        dma_wr_req_pvld;
    logic        dma_wr_req_prdy;
    logic        dma_wr_rsp_complete;
    logic        rsp0_complete;
    logic        rsp1_complete;
    logic        arb_err;
`ifdef NVDLA_DMAIF_WR_ARB_PERF_EN
    logic [31:0] arb_stall0;
    logic [31:0] arb_stall1;
`endif

    pd_t  src0_q[$];
    pd_t  src1_q[$];
    pd_t  exp_q[$];
    logic rsp_q[$];
    int   n_chk = 0;
    int   n_err = 0;
    bit   rand_rdy = 1'b0;

    nv_nvdla_dmaif_wr_arb #(.ACK_DEPTH(8)) dut (
        .nvdla_core_clk      (nvdla_core_clk),
        .nvdla_core_rstn     (nvdla_core_rstn),
        .req0_pd             (req0_pd),
        .req0_pvld           (req0_pvld),
        .req0_prdy           (req0_prdy),
        .req1_pd             (req1_pd),
        .req1_pvld           (req1_pvld),
        .req1_prdy           (req1_prdy),
        .dma_wr_req_pd       (dma_wr_req_pd),
        .dma_wr_req_pvld     (dma_wr_req_pvld),
        .dma_wr_req_prdy     (dma_wr_req_prdy),
        .dma_wr_rsp_complete (dma_wr_rsp_complete),
        .rsp0_complete       (rsp0_complete),
        .rsp1_complete       (rsp1_complete),
        .arb_err             (arb_err)
`ifdef NVDLA_DMAIF_WR_ARB_PERF_EN
        ,
        .arb_stall0          (arb_stall0),
        .arb_stall1          (arb_stall1)
`endif
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    task automatic check_eq(input string tag, input logic [65:0] got, input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic pd_t mk_cmd(input logic [31:0] addr, input logic [12:0] size, input logic ack);
        return {1'b0, 19'd0, ack, size, addr};
    endfunction

    function automatic pd_t mk_dat(input logic [31:0] v);
        return {1'b1, 33'd0, v};
    endfunction

    // Queue a whole transaction at requester r.
    task automatic send(input int r, input logic [31:0] addr, input logic [12:0] size, input logic ack);
        if (r == 0) src0_q.push_back(mk_cmd(addr, size, ack));
        else        src1_q.push_back(mk_cmd(addr, size, ack));
        for (int i = 0; i <= int'(size); i++) begin
            if (r == 0) src0_q.push_back(mk_dat({addr[15:0], 16'(i)}));
            else        src1_q.push_back(mk_dat({addr[15:0], 16'(i)}));
        end
    endtask

    task automatic expect_txn(input logic [31:0] addr, input logic [12:0] size, input logic ack);
        exp_q.push_back(mk_cmd(addr, size, ack));
        for (int i = 0; i <= int'(size); i++) exp_q.push_back(mk_dat({addr[15:0], 16'(i)}));
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            @(negedge nvdla_core_clk);
            n++;
        end
        check_eq(tag, 66'(exp_q.size()), 66'd0);
    endtask

    task automatic pulse_complete();
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b1;
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b0;
    endtask

    // Requester drivers: advance each source queue after an observed handshake.
    initial begin : drv
        bit hs0;
        bit hs1;
        forever begin
            @(negedge nvdla_core_clk);
            hs0 = req0_pvld && req0_prdy;
            hs1 = req1_pvld && req1_prdy;
            @(posedge nvdla_core_clk);
            #1;
            if (hs0 && src0_q.size() > 0) void'(src0_q.pop_front());
            if (hs1 && src1_q.size() > 0) void'(src1_q.pop_front());
            req0_pvld = (src0_q.size() > 0);
            req0_pd   = (src0_q.size() > 0) ? src0_q[0] : '0;
            req1_pvld = (src1_q.size() > 0);
            req1_pd   = (src1_q.size() > 0) ? src1_q[0] : '0;
            if (rand_rdy) dma_wr_req_prdy = 1'($urandom_range(1, 0));
        end
    end

    // Output monitor: every forwarded beat and every completion pulse is scored.
    always @(negedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            if (dma_wr_req_pvld && dma_wr_req_prdy) begin
                if (exp_q.size() == 0) check_eq("fwd_unexpected", 66'(exp_q.size()), 66'd1);
                else                   check_eq("fwd_pd", dma_wr_req_pd, exp_q.pop_front());
            end
            if (rsp0_complete || rsp1_complete) begin
                if (rsp_q.size() == 0) check_eq("rsp_unexpected", 66'(rsp_q.size()), 66'd1);
                else check_eq("rsp_id", 66'({rsp1_complete, rsp0_complete}),
                              rsp_q.pop_front() ? 66'd2 : 66'd1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nvdla_core_rstn     = 1'b0;
        req0_pd             = '0;
        req0_pvld           = 1'b0;
        req1_pd             = '0;
        req1_pvld           = 1'b0;
        dma_wr_req_prdy     = 1'b1;
        dma_wr_rsp_complete = 1'b0;
        repeat (3) @(negedge nvdla_core_clk);
        check_eq("reset_outputs", {req0_prdy, req1_prdy, dma_wr_req_pvld, rsp0_complete, rsp1_complete,
                 arb_err, dma_wr_req_pd}, '0);
        @(posedge nvdla_core_clk); #1 nvdla_core_rstn = 1'b1;

        // Simultaneous cmds from reset: requester 0 first, then requester 1.
        send(0, 32'h0000_0100, 13'd3, 1'b0);
        send(1, 32'h0000_0200, 13'd3, 1'b0);
        expect_txn(32'h0000_0100, 13'd3, 1'b0);
        expect_txn(32'h0000_0200, 13'd3, 1'b0);
        wait_drain("both_cmd_order", 60);

        // Acked write from requester 0, completion 20 cycles later.
        send(0, 32'h0000_0300, 13'd1, 1'b1);
        expect_txn(32'h0000_0300, 13'd1, 1'b1);
        wait_drain("acked_req0", 30);
        rsp_q.push_back(1'b0);
        repeat (20) @(posedge nvdla_core_clk);
        #1 dma_wr_rsp_complete = 1'b1;
        @(negedge nvdla_core_clk);
        check_eq("rsp_same_cycle", 66'({rsp1_complete, rsp0_complete}), 66'd0);
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b0;
        @(negedge nvdla_core_clk);
        check_eq("rsp_next_cycle", 66'({rsp1_complete, rsp0_complete}), 66'd1);
        @(negedge nvdla_core_clk);
        check_eq("rsp_one_cycle", 66'({rsp1_complete, rsp0_complete}), 66'd0);

        // Acked cmds in order req1, req0, req1; completions return in that order.
        send(1, 32'h0000_0410, 13'd0, 1'b1); expect_txn(32'h0000_0410, 13'd0, 1'b1);
        wait_drain("order_a", 20);
        send(0, 32'h0000_0420, 13'd2, 1'b1); expect_txn(32'h0000_0420, 13'd2, 1'b1);
        wait_drain("order_b", 20);
        send(1, 32'h0000_0430, 13'd1, 1'b1); expect_txn(32'h0000_0430, 13'd1, 1'b1);
        wait_drain("order_c", 20);
        rsp_q.push_back(1'b1); rsp_q.push_back(1'b0); rsp_q.push_back(1'b1);
        repeat (3) pulse_complete();
        repeat (3) @(negedge nvdla_core_clk);
        check_eq("rsp_order_drain", 66'(rsp_q.size()), 66'd0);

        // Fill the ack FIFO; a 9th acked cmd waits while a non-acked cmd passes.
        for (int i = 0; i < 8; i++) begin
            send(0, 32'h0000_0500 + 32'(i), 13'd0, 1'b1);
            expect_txn(32'h0000_0500 + 32'(i), 13'd0, 1'b1);
        end
        wait_drain("fifo_fill", 100);
        send(0, 32'h0000_0900, 13'd0, 1'b1);
        send(1, 32'h0000_0910, 13'd0, 1'b0);
        expect_txn(32'h0000_0910, 13'd0, 1'b0);
        wait_drain("full_bypass", 30);
        repeat (2) @(negedge nvdla_core_clk);
        check_eq("full_blocked_prdy", 66'(req0_prdy), 66'd0);
        check_eq("full_blocked_pvld", 66'(dma_wr_req_pvld), 66'd0);
        expect_txn(32'h0000_0900, 13'd0, 1'b1);
        rsp_q.push_back(1'b0);
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b1;
        @(negedge nvdla_core_clk);
        check_eq("full_unblock_prdy", 66'(req0_prdy), 66'd1);
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b0;
        wait_drain("full_unblock", 20);
        repeat (8) rsp_q.push_back(1'b0);
        repeat (8) pulse_complete();
        repeat (3) @(negedge nvdla_core_clk);
        check_eq("fifo_rsp_drain", 66'(rsp_q.size()), 66'd0);

        // Maximum-size transaction under random downstream backpressure.
        rand_rdy = 1'b1;
        send(0, 32'h0000_A000, 13'd8191, 1'b0);
        expect_txn(32'h0000_A000, 13'd8191, 1'b0);
        wait_drain("max_size_beats", 40000);
        rand_rdy = 1'b0;
        @(posedge nvdla_core_clk); #1 dma_wr_req_prdy = 1'b1;
        send(1, 32'h0000_B000, 13'd0, 1'b0);
        expect_txn(32'h0000_B000, 13'd0, 1'b0);
        wait_drain("after_max_arb", 20);
        check_eq("err_clean", 66'(arb_err), 66'd0);

        // Completion with nothing outstanding: no pulse, error flagged.
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b1;
        @(negedge nvdla_core_clk);
        @(posedge nvdla_core_clk); #1 dma_wr_rsp_complete = 1'b0;
        @(negedge nvdla_core_clk);
        check_eq("empty_no_rsp", 66'({rsp1_complete, rsp0_complete}), 66'd0);
        check_eq("empty_rsp_err", 66'(arb_err), 66'd1);

        // Reset clears the sticky error; then a data packet in ARB is stalled and flagged.
        @(posedge nvdla_core_clk); #1 nvdla_core_rstn = 1'b0;
        @(negedge nvdla_core_clk);
        check_eq("reset_mid_outputs", {req0_prdy, req1_prdy, dma_wr_req_pvld, rsp0_complete, rsp1_complete,
                 arb_err, dma_wr_req_pd}, '0);
        @(posedge nvdla_core_clk); #1 nvdla_core_rstn = 1'b1;
        src1_q.push_back(mk_dat(32'h0000_DEAD));
        repeat (3) @(negedge nvdla_core_clk);
        check_eq("data_in_arb_pvld", 66'(dma_wr_req_pvld), 66'd0);
        check_eq("data_in_arb_prdy", 66'(req1_prdy), 66'd0);
        check_eq("data_in_arb_err", 66'(arb_err), 66'd1);
        src1_q.delete();
        repeat (2) @(negedge nvdla_core_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
